// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus write-back stage.
package kamus_pkg;

  localparam int unsigned XLEN_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FUNCT3_W   = 3;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_t;

  // Byte loads never fault; reserved encodings align like LW.
  function automatic logic ld_misaligned(input logic [FUNCT3_W-1:0] f3,
                                         input logic [1:0]          off);
    logic mis;
    case (f3)
      F3_LB, F3_LBU: mis = 1'b0;
      F3_LH, F3_LHU: mis = off[0];
      default:       mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/kamus_ld_align.sv
// Combinational load formatter: selects byte/half/word from an aligned word and extends it.
module kamus_ld_align
  import kamus_pkg::*;
(
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic [1:0]          off_i,
  input  logic [XLEN_W-1:0]   word_i,
  output logic [XLEN_W-1:0]   ld_data_c_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (off_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

    ld_data_c_o = word_i;
    case (funct3_i)
      F3_LB:   ld_data_c_o = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  ld_data_c_o = {24'd0, byte_v};
      F3_LH:   ld_data_c_o = {{16{half_v[15]}}, half_v};
      F3_LHU:  ld_data_c_o = {16'd0, half_v};
      default: ld_data_c_o = word_i;
    endcase
  end

endmodule

// File: rtl/kamus_wb_stage.sv
// Write-back stage: retires MEM-stage instructions, waits on L1D loads, drives the RF write port.
// Optional ID-stage bypass outputs are enabled with KAMUS_WB_FWD_EN.
module kamus_wb_stage
  import kamus_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LD_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [XLEN-1:0]       alu_rslt_i,
  input  logic [XLEN-1:0]       pc4_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rf_we_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [FUNCT3_W-1:0]   ld_funct3_i,
  input  logic                  l1d_rd_valid_i,
  input  logic [XLEN-1:0]       l1d_rd_data_i,
  output logic                  regfile_wr_en_o,
  output logic [REG_ADDR_W-1:0] regfile_wr_addr_o,
  output logic [XLEN-1:0]       reg_wr_data_o,
  output logic                  stall_o,
  output logic                  ld_err_o
`ifdef KAMUS_WB_FWD_EN
  ,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]       fwd_data_o
`endif
);

  localparam int unsigned CNT_W = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT + 1) : 1;

  wb_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rf_we_q, rf_we_d;
  logic [FUNCT3_W-1:0]   funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic                  ld_err_q, ld_err_d;

  logic                  cap_en;
  logic                  cap_we;
  logic [REG_ADDR_W-1:0] cap_addr;
  logic [XLEN-1:0]       cap_data;
  logic                  wr_en_c;
  logic                  is_load;
  logic [XLEN-1:0]       ld_data_c;

  // Formats the returning word using the fields latched at accept.
  kamus_ld_align u_ld_align (
    .funct3_i    (funct3_q),
    .off_i       (off_q),
    .word_i      (l1d_rd_data_i),
    .ld_data_c_o (ld_data_c)
  );

  assign is_load     = (wb_sel_i == 2'(WB_LOAD));
  assign mem_ready_o = (state_q == IDLE);
  assign stall_o     = ~mem_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    rf_we_d   = rf_we_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ld_err_d  = 1'b0;
    cap_en    = 1'b0;
    cap_we    = 1'b0;
    cap_addr  = rd_addr_i;
    cap_data  = alu_rslt_i;

    case (state_q)
      IDLE: begin
        if (mem_valid_i) begin
          if (is_load) begin
            if (ld_misaligned(ld_funct3_i, alu_rslt_i[1:0])) begin
              ld_err_d = 1'b1;
            end else begin
              rd_d     = rd_addr_i;
              rf_we_d  = rf_we_i;
              funct3_d = ld_funct3_i;
              off_d    = alu_rslt_i[1:0];
              cnt_d    = '0;
              state_d  = WAIT_LD;
            end
          end else begin
            cap_en   = 1'b1;
            cap_we   = rf_we_i;
            cap_addr = rd_addr_i;
            cap_data = (wb_sel_i == 2'(WB_PC4)) ? pc4_i : alu_rslt_i;
          end
        end
      end
      WAIT_LD: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response in the timeout cycle still completes the load.
        if (l1d_rd_valid_i) begin
          cap_en   = 1'b1;
          cap_we   = rf_we_q;
          cap_addr = rd_q;
          cap_data = ld_data_c;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if ((LD_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == LD_TIMEOUT)) begin
          ld_err_d = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_en_c = cap_en & cap_we & (cap_addr != '0);
    if (wr_en_c) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cap_addr;
      wr_data_d = cap_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      rf_we_q   <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      rf_we_q   <= rf_we_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ld_err_q  <= ld_err_d;
    end
  end

  assign regfile_wr_en_o   = wr_en_q;
  assign regfile_wr_addr_o = wr_addr_q;
  assign reg_wr_data_o     = wr_data_q;
  assign ld_err_o          = ld_err_q;

`ifdef KAMUS_WB_FWD_EN
  // Bypass shows the write that lands next cycle.
  assign fwd_valid_o = wr_en_c;
  assign fwd_addr_o  = cap_addr;
  assign fwd_data_o  = cap_data;
`endif

endmodule

// File: tb/tb_kamus_wb_stage.sv
// Self-checking bench for kamus_wb_stage: vector table, corner sequences, random ops vs. a model.
module tb_kamus_wb_stage;

  localparam int unsigned LD_TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] alu_rslt;
  logic [31:0] pc4;
  logic [4:0]  rd_addr;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  ld_funct3;
  logic        l1d_valid;
  logic [31:0] l1d_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        stall;
  logic        ld_err;
`ifdef KAMUS_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  kamus_wb_stage #(.XLEN(32), .LD_TIMEOUT(LD_TO)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .mem_valid_i       (mem_valid),
    .mem_ready_o       (mem_ready),
    .alu_rslt_i        (alu_rslt),
    .pc4_i             (pc4),
    .rd_addr_i         (rd_addr),
    .rf_we_i           (rf_we),
    .wb_sel_i          (wb_sel),
    .ld_funct3_i       (ld_funct3),
    .l1d_rd_valid_i    (l1d_valid),
    .l1d_rd_data_i     (l1d_data),
    .regfile_wr_en_o   (wr_en),
    .regfile_wr_addr_o (wr_addr),
    .reg_wr_data_o     (wr_data),
    .stall_o           (stall),
    .ld_err_o          (ld_err)
`ifdef KAMUS_WB_FWD_EN
    ,
    .fwd_valid_o       (fwd_valid),
    .fwd_addr_o        (fwd_addr),
    .fwd_data_o        (fwd_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: load result from plain shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned b, h, o;
    o = 32'(off);
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] off);
    int unsigned o;
    o = 32'(off);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (o % 2) != 0;
    return o != 0;
  endfunction

  // One complete transaction; lat = wait cycle (1-based) in which L1D answers.
  task automatic do_op(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] p4,
                       input logic [31:0] word, input int lat);
    bit exp_we;
    exp_we = we && (rd != 5'd0);
    mem_valid = 1'b1; wb_sel = sel; rd_addr = rd; rf_we = we;
    ld_funct3 = f3; alu_rslt = alu; pc4 = p4;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    if (sel != 2'd1) begin
      chk("op_wr_en", 32'(wr_en), 32'(exp_we));
      if (exp_we) begin
        chk("op_wr_addr", 32'(wr_addr), 32'(rd));
        chk("op_wr_data", wr_data, (sel == 2'd2) ? p4 : alu);
      end
      chk("op_ld_err", 32'(ld_err), 32'd0);
    end else if (ref_misaligned(f3, alu[1:0])) begin
      chk("mis_ld_err", 32'(ld_err), 32'd1);
      chk("mis_wr_en", 32'(wr_en), 32'd0);
      chk("mis_stall", 32'(stall), 32'd0);
    end else begin
      for (int c = 1; c <= int'(LD_TO); c++) begin
        chk("ld_stall", 32'(stall), 32'd1);
        if (c == lat) begin
          l1d_valid = 1'b1; l1d_data = word;
        end else begin
          l1d_data = $urandom;
        end
        @(posedge clk); #1;
        l1d_valid = 1'b0;
        if (c == lat) break;
      end
      if (lat <= int'(LD_TO)) begin
        chk("ld_wr_en", 32'(wr_en), 32'(exp_we));
        if (exp_we) begin
          chk("ld_wr_addr", 32'(wr_addr), 32'(rd));
          chk("ld_wr_data", wr_data, ref_load(f3, alu[1:0], word));
        end
        chk("ld_err_none", 32'(ld_err), 32'd0);
      end else begin
        chk("to_ld_err", 32'(ld_err), 32'd1);
        chk("to_wr_en", 32'(wr_en), 32'd0);
      end
      chk("ld_done_stall", 32'(stall), 32'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 5'd5,  1'b1, 32'h0000_1234, 32'h0000_0010, 1'b1, 5'd5,  32'h0000_1234};
    tbl[1] = '{2'd2, 5'd1,  1'b1, 32'h5555_0000, 32'h0000_0080, 1'b1, 5'd1,  32'h0000_0080};
    tbl[2] = '{2'd0, 5'd0,  1'b1, 32'h0000_00AA, 32'h0000_0000, 1'b0, 5'd0,  32'h0};
    tbl[3] = '{2'd0, 5'd12, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0, 5'd0,  32'h0};
    tbl[4] = '{2'd2, 5'd2,  1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 5'd2,  32'hFFFF_FFFC};
    tbl[5] = '{2'd0, 5'd31, 1'b1, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 5'd31, 32'hCAFE_F00D};
    tbl[6] = '{2'd0, 5'd6,  1'b1, 32'h0000_0055, 32'h0000_0000, 1'b1, 5'd6,  32'h0000_0055};
    tbl[7] = '{2'd0, 5'd7,  1'b1, 32'h0000_0066, 32'h0000_0000, 1'b1, 5'd7,  32'h0000_0066};

    rst = 1'b1; mem_valid = 1'b0; alu_rslt = '0; pc4 = '0; rd_addr = '0; rf_we = 1'b0;
    wb_sel = 2'd0; ld_funct3 = 3'd0; l1d_valid = 1'b0; l1d_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // Back-to-back non-load accepts, one per cycle.
    for (int i = 0; i < 8; i++) begin
      mem_valid = 1'b1; wb_sel = tbl[i].sel; rd_addr = tbl[i].rd; rf_we = tbl[i].we;
      alu_rslt = tbl[i].alu; pc4 = tbl[i].pc4;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].exp_en));
      if (tbl[i].exp_en) begin
        chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].exp_addr));
        chk($sformatf("vec%0d_wr_data", i), wr_data, tbl[i].exp_data);
      end
      chk($sformatf("vec%0d_ready", i), 32'(mem_ready), 32'd1);
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_wr_en", 32'(wr_en), 32'd0);

    // LB / LBU at byte offset 3, response in the second wait cycle.
    do_op(2'd1, 5'd9, 1'b1, 3'd0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 2);
    chk("lb_data", wr_data, 32'hFFFF_FF80);
    @(posedge clk); #1;
    chk("lb_pulse_drop", 32'(wr_en), 32'd0);
    do_op(2'd1, 5'd9, 1'b1, 3'd4, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 2);
    chk("lbu_data", wr_data, 32'h0000_0080);

    // Misaligned LH.
    do_op(2'd1, 5'd3, 1'b1, 3'd1, 32'h0000_1001, 32'h0, 32'h0, 1);
    @(posedge clk); #1;
    chk("mis_err_drop", 32'(ld_err), 32'd0);

    // LW timeout, then a late response must be ignored.
    do_op(2'd1, 5'd4, 1'b1, 3'd2, 32'h0000_0100, 32'h0, 32'h1111_2222, 6);
    l1d_valid = 1'b1; l1d_data = 32'h1111_2222;
    @(posedge clk); #1;
    l1d_valid = 1'b0;
    chk("late_wr_en", 32'(wr_en), 32'd0);
    chk("late_ld_err", 32'(ld_err), 32'd0);
    chk("late_stall", 32'(stall), 32'd0);

    // Reset while a load is outstanding.
    mem_valid = 1'b1; wb_sel = 2'd1; rd_addr = 5'd3; rf_we = 1'b1;
    ld_funct3 = 3'd2; alu_rslt = 32'h0000_0200;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("rstld_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #2;
    chk("rstld_ready", 32'(mem_ready), 32'd1);
    rst = 1'b0;
    l1d_valid = 1'b1; l1d_data = 32'hABCD_0123;
    @(posedge clk); #1;
    l1d_valid = 1'b0;
    chk("rstld_wr_en", 32'(wr_en), 32'd0);
    chk("rstld_ready2", 32'(mem_ready), 32'd1);

`ifdef KAMUS_WB_FWD_EN
    mem_valid = 1'b1; wb_sel = 2'd1; rd_addr = 5'd7; rf_we = 1'b1;
    ld_funct3 = 3'd2; alu_rslt = 32'h0000_2000;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    l1d_valid = 1'b1; l1d_data = 32'hDEAD_BEEF;
    #1;
    chk("fwd_valid", 32'(fwd_valid), 32'd1);
    chk("fwd_addr", 32'(fwd_addr), 32'd7);
    chk("fwd_data", fwd_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    l1d_valid = 1'b0;
    chk("fwd_wr_data", wr_data, 32'hDEAD_BEEF);
`endif

    // Random mix checked against the reference functions.
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  s;
      logic [2:0]  f;
      int          pick;
      s = 2'($urandom_range(0, 2));
      pick = $urandom_range(0, 6);
      case (pick)
        0: f = 3'd0; 1: f = 3'd1; 2: f = 3'd2; 3: f = 3'd4; 4: f = 3'd5;
        5: f = 3'd3; default: f = 3'd7;
      endcase
      do_op(s, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), f,
            $urandom, $urandom, $urandom, $urandom_range(1, 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
